// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - AXI4 INCR burst initiator: pattern write, read-back check
// Optional macro AXI_BURST_MASTER_CHECK_EN builds the RDATA compare and mismatch counter.

package axi_burst_master_pkg;
   localparam int AXI_ID_W   = 4;
   localparam int AXI_ID_R   = 4;
   localparam int AXI_ADDR   = 16;
   localparam int AXI_DATA   = 32;
   localparam int AXI_USER   = 4;
   localparam int AXI_BYTE   = 8;
   localparam int AXI_STRB   = AXI_DATA / AXI_BYTE;

   typedef struct packed {
      logic [AXI_ID_W-1:0] aw_id;
      logic [AXI_ADDR-1:0] aw_addr;
      logic [7:0]          aw_len;
      logic [2:0]          aw_size;
      logic [1:0]          aw_burst;
      logic [AXI_USER-1:0] aw_user;
      logic                aw_valid;
      logic [AXI_DATA-1:0] w_data;
      logic [AXI_STRB-1:0] w_strb;
      logic                w_last;
      logic [AXI_USER-1:0] w_user;
      logic                w_valid;
      logic                b_ready;
      logic [AXI_ID_R-1:0] ar_id;
      logic [AXI_ADDR-1:0] ar_addr;
      logic [7:0]          ar_len;
      logic [2:0]          ar_size;
      logic [1:0]          ar_burst;
      logic [AXI_USER-1:0] ar_user;
      logic                ar_valid;
      logic                r_ready;
   } axi_mosi_t;

   typedef struct packed {
      logic                aw_ready;
      logic                w_ready;
      logic [AXI_ID_W-1:0] b_id;
      logic [1:0]          b_resp;
      logic                b_valid;
      logic                ar_ready;
      logic [AXI_ID_R-1:0] r_id;
      logic [AXI_DATA-1:0] r_data;
      logic [1:0]          r_resp;
      logic                r_last;
      logic                r_valid;
   } axi_miso_t;
endpackage

module axi_burst_master
   import axi_burst_master_pkg::*;
#(
   parameter int ID_W_WIDTH = AXI_ID_W,
   parameter int ID_R_WIDTH = AXI_ID_R,
   parameter int ADDR_WIDTH = AXI_ADDR,
   parameter int DATA_WIDTH = AXI_DATA,
   parameter int BYTE_WIDTH = AXI_BYTE
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [7:0]            cmd_len_i,
   input  logic [ID_W_WIDTH-1:0] cmd_id_i,
   input  logic [DATA_WIDTH-1:0] cmd_seed_i,
   output logic                  done_o,
   output logic                  resp_err_o,
   output logic [15:0]           mismatch_o,
   output axi_mosi_t             out_mosi_o,
   input  axi_miso_t             out_miso_i
);

   localparam logic [2:0] AXI_SIZE = 3'($clog2(DATA_WIDTH / 8));

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

   state_t state, state_n;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [ID_W_WIDTH-1:0] id_q;
   logic [DATA_WIDTH-1:0] seed_q;
   logic [7:0]            beat_q;
   logic                  err_q;
   logic                  done_q;
   logic                  aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;

   logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                  last_beat;
   logic [DATA_WIDTH-1:0] pattern;

   assign aw_hs     = aw_valid_q & out_miso_i.aw_ready;
   assign w_hs      = w_valid_q  & out_miso_i.w_ready;
   assign b_hs      = b_ready_q  & out_miso_i.b_valid;
   assign ar_hs     = ar_valid_q & out_miso_i.ar_ready;
   assign r_hs      = r_ready_q  & out_miso_i.r_valid;
   assign last_beat = (beat_q == len_q);
   assign pattern   = seed_q + DATA_WIDTH'(beat_q);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (cmd_valid_i) state_n = cmd_write_i ? S_AW : S_AR;
         S_AW:   if (aw_hs) state_n = S_W;
         S_W:    if (w_hs && last_beat) state_n = S_B;
         S_B:    if (b_hs) state_n = S_IDLE;
         S_AR:   if (ar_hs) state_n = S_R;
         S_R:    if (r_hs && out_miso_i.r_last) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Channel VALID/READY are registered copies of the next state.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         len_q      <= '0;
         id_q       <= '0;
         seed_q     <= '0;
         beat_q     <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         aw_valid_q <= (state_n == S_AW);
         w_valid_q  <= (state_n == S_W);
         b_ready_q  <= (state_n == S_B);
         ar_valid_q <= (state_n == S_AR);
         r_ready_q  <= (state_n == S_R);
         case (state)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  addr_q <= cmd_addr_i;
                  len_q  <= cmd_len_i;
                  id_q   <= cmd_id_i;
                  seed_q <= cmd_seed_i;
                  beat_q <= '0;
                  err_q  <= 1'b0;
               end
            end
            S_W: begin
               if (w_hs) beat_q <= beat_q + 8'd1;
            end
            S_B: begin
               if (b_hs) begin
                  if (out_miso_i.b_resp != 2'b00 || out_miso_i.b_id != id_q) err_q <= 1'b1;
                  done_q <= 1'b1;
               end
            end
            S_R: begin
               if (r_hs) begin
                  beat_q <= beat_q + 8'd1;
                  // RLAST must coincide exactly with the final expected beat.
                  if (out_miso_i.r_resp != 2'b00 || (out_miso_i.r_last != last_beat)) err_q <= 1'b1;
                  if (out_miso_i.r_last) done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef AXI_BURST_MASTER_CHECK_EN
   logic [15:0] mism_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         mism_q <= '0;
      end else if (state == S_IDLE && cmd_valid_i) begin
         mism_q <= '0;
      end else if (r_hs && out_miso_i.r_data != pattern && mism_q != 16'hFFFF) begin
         mism_q <= mism_q + 16'd1;
      end
   end

   assign mismatch_o = mism_q;
   wire unused_miso = ^{out_miso_i.r_id};
`else
   assign mismatch_o = '0;
   wire unused_miso = ^{out_miso_i.r_id, out_miso_i.r_data};
`endif

   assign cmd_ready_o = (state == S_IDLE);
   assign done_o      = done_q;
   assign resp_err_o  = err_q;

   // Payloads are gated by their VALID so they read zero whenever the channel is idle.
   always_comb begin
      out_mosi_o = '0;
      out_mosi_o.aw_valid = aw_valid_q;
      out_mosi_o.w_valid  = w_valid_q;
      out_mosi_o.b_ready  = b_ready_q;
      out_mosi_o.ar_valid = ar_valid_q;
      out_mosi_o.r_ready  = r_ready_q;
      if (aw_valid_q) begin
         out_mosi_o.aw_id    = id_q;
         out_mosi_o.aw_addr  = addr_q;
         out_mosi_o.aw_len   = len_q;
         out_mosi_o.aw_size  = AXI_SIZE;
         out_mosi_o.aw_burst = 2'b01;
      end
      if (w_valid_q) begin
         out_mosi_o.w_data = pattern;
         out_mosi_o.w_strb = {(DATA_WIDTH/BYTE_WIDTH){1'b1}};
         out_mosi_o.w_last = last_beat;
      end
      if (ar_valid_q) begin
         out_mosi_o.ar_id    = id_q[ID_R_WIDTH-1:0];
         out_mosi_o.ar_addr  = addr_q;
         out_mosi_o.ar_len   = len_q;
         out_mosi_o.ar_size  = AXI_SIZE;
         out_mosi_o.ar_burst = 2'b01;
      end
   end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - directed bench for axi_burst_master with a memory responder
// Mismatch expectations follow AXI_BURST_MASTER_CHECK_EN.
`timescale 1ns/1ps

module tb_axi_burst_master;
   import axi_burst_master_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [15:0] cmd_addr = '0;
   logic [7:0]  cmd_len = '0;
   logic [3:0]  cmd_id = '0;
   logic [31:0] cmd_seed = '0;
   logic        done;
   logic        resp_err;
   logic [15:0] mismatch;
   axi_mosi_t   mosi;
   axi_miso_t   miso;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_burst_master dut (
      .clk_in(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_id_i(cmd_id), .cmd_seed_i(cmd_seed),
      .done_o(done), .resp_err_o(resp_err), .mismatch_o(mismatch),
      .out_mosi_o(mosi), .out_miso_i(miso)
   );

   // Responder / monitor state
   logic [31:0] mem [0:1023];
   logic [31:0] w_log [0:255];
   bit          wl_log [0:255];
   bit          stall_en = 0;
   logic [1:0]  bresp_inj = 2'b00;
   int          rlast_at = -1;
   logic [15:0] aw_addr_c, ar_addr_c;
   logic [7:0]  aw_len_c, ar_len_c;
   logic [2:0]  aw_size_c, ar_size_c;
   logic [1:0]  aw_burst_c, ar_burst_c;
   logic [3:0]  aw_id_c, ar_id_c;
   int          w_cnt = 0, r_cnt = 0, done_cnt = 0, stab_err = 0, strb_bad = 0, aw_cnt = 0;
   bit          b_pend = 0, r_act = 0;
   int          r_beat = 0;
   bit          aw_st = 0, w_st = 0, ar_st = 0;
   logic [33:0] aw_snap;
   logic [36:0] w_snap;
   logic [33:0] ar_snap;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_pend <= 0; r_act <= 0; r_beat <= 0;
         aw_st <= 0; w_st <= 0; ar_st <= 0;
      end else begin
         stab_err <= stab_err
            + int'(aw_st && (!mosi.aw_valid || aw_snap != {mosi.aw_id, mosi.aw_addr, mosi.aw_len, mosi.aw_size, mosi.aw_burst}))
            + int'(w_st && (!mosi.w_valid || w_snap != {mosi.w_data, mosi.w_strb, mosi.w_last}))
            + int'(ar_st && (!mosi.ar_valid || ar_snap != {mosi.ar_id, mosi.ar_addr, mosi.ar_len, mosi.ar_size, mosi.ar_burst}));
         aw_st   <= mosi.aw_valid && !miso.aw_ready;
         w_st    <= mosi.w_valid && !miso.w_ready;
         ar_st   <= mosi.ar_valid && !miso.ar_ready;
         aw_snap <= {mosi.aw_id, mosi.aw_addr, mosi.aw_len, mosi.aw_size, mosi.aw_burst};
         w_snap  <= {mosi.w_data, mosi.w_strb, mosi.w_last};
         ar_snap <= {mosi.ar_id, mosi.ar_addr, mosi.ar_len, mosi.ar_size, mosi.ar_burst};
         if (mosi.aw_valid && miso.aw_ready) begin
            aw_addr_c <= mosi.aw_addr; aw_len_c <= mosi.aw_len; aw_size_c <= mosi.aw_size;
            aw_burst_c <= mosi.aw_burst; aw_id_c <= mosi.aw_id; aw_cnt <= aw_cnt + 1;
         end
         if (mosi.w_valid && miso.w_ready) begin
            mem[(int'(aw_addr_c[11:2]) + w_cnt) % 1024] <= mosi.w_data;
            if (w_cnt < 256) begin
               w_log[w_cnt]  <= mosi.w_data;
               wl_log[w_cnt] <= mosi.w_last;
            end
            if (mosi.w_strb != 4'hF) strb_bad <= strb_bad + 1;
            w_cnt <= w_cnt + 1;
            if (mosi.w_last) b_pend <= 1;
         end
         if (mosi.b_ready && miso.b_valid) b_pend <= 0;
         if (mosi.ar_valid && miso.ar_ready) begin
            ar_addr_c <= mosi.ar_addr; ar_len_c <= mosi.ar_len; ar_size_c <= mosi.ar_size;
            ar_burst_c <= mosi.ar_burst; ar_id_c <= mosi.ar_id;
            r_act <= 1; r_beat <= 0;
         end
         if (mosi.r_ready && miso.r_valid) begin
            r_cnt <= r_cnt + 1;
            if (miso.r_last) r_act <= 0;
            else r_beat <= r_beat + 1;
         end
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         miso = '0;
      end else begin
         miso.aw_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
         miso.w_ready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
         miso.ar_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
         miso.b_valid  = b_pend;
         miso.b_resp   = b_pend ? bresp_inj : 2'b00;
         miso.b_id     = aw_id_c;
         miso.r_valid  = r_act;
         miso.r_id     = ar_id_c;
         miso.r_resp   = 2'b00;
         miso.r_data   = mem[(int'(ar_addr_c[11:2]) + r_beat) % 1024];
         miso.r_last   = r_act && ((rlast_at >= 0) ? (r_beat == rlast_at) : (r_beat == int'(ar_len_c)));
      end
   end

   task automatic issue(input bit wr, input logic [15:0] a, input logic [7:0] l,
                        input logic [3:0] id, input logic [31:0] s);
      @(negedge clk);
      w_cnt = 0; r_cnt = 0; done_cnt = 0; stab_err = 0; strb_bad = 0; aw_cnt = 0;
      cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id; cmd_seed = s; cmd_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic wait_done(output bit got, output logic err, output logic [15:0] mm, output logic rdy);
      got = 0; err = 0; mm = 0; rdy = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            got = 1; err = resp_err; mm = mismatch; rdy = cmd_ready;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      checks++; if (mosi !== '0) begin errors++; $display("FAIL reset_mosi got %h want 0", mosi); end
      checks++; if ({done, resp_err, mismatch} !== 18'h0) begin errors++; $display("FAIL reset_status got %h want 0", {done, resp_err, mismatch}); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_write_basic();
      bit got; logic err, rdy; logic [15:0] mm; int bad;
      issue(1, 16'h0010, 8'd3, 4'h5, 32'hA0);
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_cmd_ready got %b want 0", cmd_ready); end
      // a command presented while busy must be ignored
      cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0200;
      @(negedge clk);
      cmd_valid = 0;
      wait_done(got, err, mm, rdy);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL wr_done got %b want 1", got); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", err); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL wr_ready_at_done got %b want 1", rdy); end
      checks++; if ({aw_addr_c, aw_len_c, aw_size_c, aw_burst_c, aw_id_c} !== {16'h0010, 8'd3, 3'd2, 2'b01, 4'h5}) begin
         errors++; $display("FAIL wr_aw got %h/%0d/%0d/%0d/%h want 0010/3/2/1/5", aw_addr_c, aw_len_c, aw_size_c, aw_burst_c, aw_id_c);
      end
      checks++; if (w_cnt !== 4) begin errors++; $display("FAIL wr_beats got %0d want 4", w_cnt); end
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (w_log[i] !== 32'hA0 + i) bad++;
         if (wl_log[i] !== (i == 3)) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL wr_data_last got %0d bad want 0", bad); end
      checks++; if (strb_bad !== 0) begin errors++; $display("FAIL wr_strb got %0d bad want 0", strb_bad); end
      repeat (3) @(negedge clk);
      checks++; if ({done_cnt, aw_cnt} !== {32'd1, 32'd1}) begin errors++; $display("FAIL wr_pulses got done=%0d aw=%0d want 1/1", done_cnt, aw_cnt); end
   endtask

   task automatic test_read(input logic [31:0] seed, input logic [15:0] exp_mm, input string nm);
      bit got; logic err, rdy; logic [15:0] mm;
      issue(0, 16'h0010, 8'd3, 4'h6, seed);
      wait_done(got, err, mm, rdy);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL %s_done got %b want 1", nm, got); end
      checks++; if ({err, mm} !== {1'b0, exp_mm}) begin errors++; $display("FAIL %s_err_mm got %b/%0d want 0/%0d", nm, err, mm, exp_mm); end
      checks++; if ({ar_addr_c, ar_len_c, ar_size_c, ar_burst_c, ar_id_c} !== {16'h0010, 8'd3, 3'd2, 2'b01, 4'h6}) begin
         errors++; $display("FAIL %s_ar got %h/%0d/%0d/%0d/%h want 0010/3/2/1/6", nm, ar_addr_c, ar_len_c, ar_size_c, ar_burst_c, ar_id_c);
      end
      @(negedge clk);
      checks++; if (r_cnt !== 4) begin errors++; $display("FAIL %s_beats got %0d want 4", nm, r_cnt); end
   endtask

   task automatic test_stall_long();
      bit got; logic err, rdy; logic [15:0] mm; int bad, lasts;
      stall_en = 1;
      issue(1, 16'h0400, 8'd255, 4'h3, 32'hFFFF_FFF0);
      wait_done(got, err, mm, rdy);
      checks++; if ({got, err} !== 2'b10) begin errors++; $display("FAIL stall_wr_done_err got %b want 10", {got, err}); end
      repeat (3) @(negedge clk);
      checks++; if (w_cnt !== 256) begin errors++; $display("FAIL stall_wr_beats got %0d want 256", w_cnt); end
      bad = 0; lasts = 0;
      for (int i = 0; i < 256; i++) begin
         if (w_log[i] !== 32'hFFFF_FFF0 + 32'(i)) bad++;
         if (wl_log[i]) lasts++;
      end
      checks++; if ({bad, lasts, 31'd0, wl_log[255]} !== {32'd0, 32'd1, 32'd1}) begin
         errors++; $display("FAIL stall_wr_data got bad=%0d lasts=%0d last255=%b want 0/1/1", bad, lasts, wl_log[255]);
      end
      checks++; if (stab_err !== 0) begin errors++; $display("FAIL stall_wr_stable got %0d want 0", stab_err); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_wr_pulses got %0d want 1", done_cnt); end
      issue(0, 16'h0400, 8'd255, 4'h3, 32'hFFFF_FFF0);
      wait_done(got, err, mm, rdy);
      checks++; if ({got, err, mm} !== {2'b10, 16'd0}) begin errors++; $display("FAIL stall_rd got %b/%b/%0d want 1/0/0", got, err, mm); end
      @(negedge clk);
      checks++; if ({r_cnt, stab_err} !== {32'd256, 32'd0}) begin errors++; $display("FAIL stall_rd_beats got %0d/%0d want 256/0", r_cnt, stab_err); end
      stall_en = 0;
   endtask

   task automatic test_resp_errors();
      bit got; logic err, rdy; logic [15:0] mm;
      bresp_inj = 2'b10;
      issue(1, 16'h0020, 8'd1, 4'h2, 32'h11);
      wait_done(got, err, mm, rdy);
      checks++; if ({got, err} !== 2'b11) begin errors++; $display("FAIL bresp_err got %b want 11", {got, err}); end
      bresp_inj = 2'b00;
      rlast_at = 1;
      issue(0, 16'h0010, 8'd3, 4'h6, 32'hA0);
      wait_done(got, err, mm, rdy);
      checks++; if ({got, err, mm} !== {2'b11, 16'd0}) begin errors++; $display("FAIL rlast_early got %b/%b/%0d want 1/1/0", got, err, mm); end
      @(negedge clk);
      checks++; if (r_cnt !== 2) begin errors++; $display("FAIL rlast_early_beats got %0d want 2", r_cnt); end
      rlast_at = -1;
   endtask

   task automatic test_reset_mid();
      bit got, hit; logic err, rdy; logic [15:0] mm; int bad;
      issue(1, 16'h0040, 8'd7, 4'h9, 32'h55);
      hit = 0;
      for (int i = 0; i < 100; i++) begin
         if (w_cnt == 2) begin hit = 1; break; end
         @(negedge clk);
      end
      checks++; if (hit !== 1'b1) begin errors++; $display("FAIL mid_reach_beat2 got %b want 1", hit); end
      rst_n = 0;
      #1;
      checks++; if ({mosi.aw_valid, mosi.w_valid, mosi.ar_valid, mosi.b_ready, mosi.r_ready, done} !== 6'b0) begin
         errors++; $display("FAIL mid_reset_valids got %b want 0", {mosi.aw_valid, mosi.w_valid, mosi.ar_valid, mosi.b_ready, mosi.r_ready, done});
      end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_idle got %b want 1", cmd_ready); end
      issue(1, 16'h0060, 8'd2, 4'h4, 32'h300);
      wait_done(got, err, mm, rdy);
      checks++; if ({got, err} !== 2'b10) begin errors++; $display("FAIL mid_new_done got %b want 10", {got, err}); end
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 3; i++) if (w_log[i] !== 32'h300 + i || wl_log[i] !== (i == 2)) bad++;
      checks++; if ({w_cnt, bad} !== {32'd3, 32'd0}) begin errors++; $display("FAIL mid_new_data got beats=%0d bad=%0d want 3/0", w_cnt, bad); end
   endtask

   initial begin
      miso = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      test_reset();
      test_write_basic();
      test_read(32'hA0, 16'd0, "rd_ok");
`ifdef AXI_BURST_MASTER_CHECK_EN
      test_read(32'hA1, 16'd4, "rd_bad");
`else
      test_read(32'hA1, 16'd0, "rd_bad");
`endif
      test_stall_long();
      test_resp_errors();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
